// File: rtl/edu_dp_pkg.sv
// rtl/edu_dp_pkg.sv - shared enums, flag indices and branch-condition helper for param_data_path
package edu_dp_pkg;

  typedef enum logic [3:0] {
    TR_NONE    = 4'h0,
    TR_MA_PC   = 4'h1,
    TR_MEM_RD  = 4'h2,
    TR_IR_MD   = 4'h3,
    TR_MA_MD   = 4'h4,
    TR_ACC_MD  = 4'h5,
    TR_MA_AP   = 4'h6,
    TR_MA_SP   = 4'h7,
    TR_MD_ACC  = 4'h8,
    TR_MEM_WR  = 4'h9,
    TR_ACC_R   = 4'hA,
    TR_PC_COND = 4'hB,
    TR_A_IN    = 4'hC,
    TR_OUT_A   = 4'hD,
    TR_PC_AP   = 4'hE,
    TR_MD_PC   = 4'hF
  } xfer_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_NOT = 4'h2,
    ALU_OR  = 4'h3,
    ALU_AND = 4'h4,
    ALU_XOR = 4'h5,
    ALU_SHR = 4'h6,
    ALU_SHL = 4'h7,
    ALU_ROR = 4'h8,
    ALU_ROL = 4'h9
  } alu_op_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_Z      = 2'b01,
    COND_C      = 2'b10,
    COND_N      = 2'b11
  } cond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  function automatic logic cond_met(input logic [1:0] cond, input logic [3:0] flags);
    case (cond)
      COND_Z:  cond_met = flags[FLAG_Z];
      COND_C:  cond_met = flags[FLAG_C];
      COND_N:  cond_met = flags[FLAG_N];
      default: cond_met = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/param_data_path_if.sv
// rtl/param_data_path_if.sv - memory request/acknowledge bus bundle with master/slave views
interface param_data_path_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/edu_dp_alu.sv
// rtl/edu_dp_alu.sv - combinational ALU, result plus {V,N,C,Z}; EDU_DP_ROTATE_EN adds ROR/ROL through carry
module edu_dp_alu
  import edu_dp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_op,
  input  logic              i_c,
  output logic [DATA_W-1:0] o_res,
  output logic [3:0]        o_flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] res;
  logic              c;
  logic              v;

`ifndef EDU_DP_ROTATE_EN
  logic unused_c;
  assign unused_c = i_c;
`endif

  always_comb begin
    wide = '0;
    res  = '1;
    c    = 1'b0;
    v    = 1'b0;
    case (i_op)
      ALU_ADD: begin
        wide = {1'b0, i_a} + {1'b0, i_b};
        res  = wide[MSB:0];
        c    = wide[DATA_W];
        v    = (i_a[MSB] == i_b[MSB]) && (res[MSB] != i_a[MSB]);
      end
      ALU_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        wide = {1'b0, i_a} - {1'b0, i_b};
        res  = wide[MSB:0];
        c    = wide[DATA_W];
        v    = (i_a[MSB] != i_b[MSB]) && (res[MSB] != i_a[MSB]);
      end
      ALU_NOT: res = ~i_a;
      ALU_OR:  res = i_a | i_b;
      ALU_AND: res = i_a & i_b;
      ALU_XOR: res = i_a ^ i_b;
      ALU_SHR: begin
        res = i_a >> 1;
        c   = i_a[0];
      end
      ALU_SHL: begin
        res = i_a << 1;
        c   = i_a[MSB];
      end
`ifdef EDU_DP_ROTATE_EN
      ALU_ROR: begin
        res = {i_c, i_a[MSB:1]};
        c   = i_a[0];
      end
      ALU_ROL: begin
        res = {i_a[MSB-1:0], i_c};
        c   = i_a[MSB];
      end
`endif
      default: res = '1;
    endcase
  end

  always_comb begin
    o_res           = res;
    o_flags         = '0;
    o_flags[FLAG_Z] = (res == '0);
    o_flags[FLAG_N] = res[MSB];
    o_flags[FLAG_C] = c;
    o_flags[FLAG_V] = v;
  end

endmodule

// File: rtl/param_data_path.sv
// rtl/param_data_path.sv - register-transfer datapath with ALU, PC/SP, IR and a two-state memory handshake
module param_data_path
  import edu_dp_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int SP_INIT = 2**(ADDR_W-1)-1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [3:0]        i_transfer_cmd,
  input  logic              i_alu_calculate,
  input  logic [3:0]        i_alu_op,
  input  logic              i_alu_res_to_ap,
  input  logic [1:0]        i_cond,
  input  logic              i_inc_pc,
  input  logic [1:0]        i_inc_dec_sp,
  input  logic              i_reset_ir,
  input  logic [DATA_W-1:0] i_in,
  output logic [DATA_W-1:0] o_out,
  output logic [DATA_W-1:0] o_ir,
  output logic [3:0]        o_flags,
  output logic              o_busy,
  output logic              o_sp_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, sp_q, sp_d, ma_q, ma_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] md_q, md_d, ir_q, ir_d, a_q, a_d, ap_q, ap_d;
  logic [DATA_W-1:0] r_q, r_d, in_q, in_d, out_q, out_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]        flags_q, flags_d;
  logic              sp_err_q, sp_err_d, mem_we_q, mem_we_d;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;
  logic              busy;

  assign acc  = i_alu_res_to_ap ? ap_q : a_q;
  assign busy = (state_q == ST_REQ);

  edu_dp_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a     (acc),
    .i_b     (md_q),
    .i_op    (i_alu_op),
    .i_c     (flags_q[FLAG_C]),
    .o_res   (alu_res),
    .o_flags (alu_flags)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    ma_d        = ma_q;
    md_d        = md_q;
    ir_d        = ir_q;
    a_d         = a_q;
    ap_d        = ap_q;
    r_d         = r_q;
    in_d        = i_in;
    out_d       = out_q;
    flags_d     = flags_q;
    sp_err_d    = sp_err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (i_alu_calculate) begin
      r_d     = alu_res;
      flags_d = alu_flags;
    end

    if (i_inc_pc) pc_d = pc_q + ADDR_W'(1);

    case (i_inc_dec_sp)
      2'b01: begin
        sp_d = sp_q + ADDR_W'(1);
        if (sp_q == '1) sp_err_d = 1'b1;
      end
      2'b10: begin
        sp_d = sp_q - ADDR_W'(1);
        if (sp_q == '0) sp_err_d = 1'b1;
      end
      default: ;
    endcase

    // Transfers are dropped while a memory access is outstanding.
    if (!busy) begin
      case (i_transfer_cmd)
        TR_MA_PC:  ma_d = pc_q;
        TR_MEM_RD, TR_MEM_WR: begin
          state_d     = ST_REQ;
          mem_we_d    = (i_transfer_cmd == TR_MEM_WR);
          mem_addr_d  = ma_q;
          mem_wdata_d = md_q;
        end
        TR_IR_MD:  ir_d = md_q;
        TR_MA_MD:  ma_d = md_q[ADDR_W-1:0];
        TR_ACC_MD: if (i_alu_res_to_ap) ap_d = md_q; else a_d = md_q;
        TR_MA_AP:  ma_d = ap_q[ADDR_W-1:0];
        TR_MA_SP:  ma_d = sp_q;
        TR_MD_ACC: md_d = acc;
        TR_ACC_R:  if (i_alu_res_to_ap) ap_d = r_q; else a_d = r_q;
        TR_PC_COND: if (cond_met(i_cond, flags_q)) pc_d = md_q[ADDR_W-1:0];
        TR_A_IN:   a_d = in_q;
        TR_OUT_A:  out_d = a_q;
        TR_PC_AP:  pc_d = ap_q[ADDR_W-1:0];
        TR_MD_PC:  md_d = DATA_W'(pc_q);
        default: ;
      endcase
    end else if (i_mem_ack) begin
      state_d = ST_IDLE;
      if (!mem_we_q) md_d = i_mem_rdata;
    end

    if (i_reset_ir) ir_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      sp_q        <= ADDR_W'(SP_INIT);
      ma_q        <= '0;
      md_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      ap_q        <= '0;
      r_q         <= '0;
      in_q        <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      sp_err_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      ma_q        <= ma_d;
      md_q        <= md_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      ap_q        <= ap_d;
      r_q         <= r_d;
      in_q        <= in_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      sp_err_q    <= sp_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_out       = out_q;
  assign o_ir        = ir_q;
  assign o_flags     = flags_q;
  assign o_busy      = busy;
  assign o_sp_err    = sp_err_q;
  assign o_mem_req   = busy;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_param_data_path.sv
// tb/tb_param_data_path.sv - scoreboard bench: memory requests checked by a monitor, flags/outputs checked directly
module tb_param_data_path;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] cmd;
  logic       calc;
  logic [3:0] op;
  logic       to_ap;
  logic [1:0] cond;
  logic       inc_pc;
  logic [1:0] incdec;
  logic       rst_ir;
  logic [7:0] din;
  logic [7:0] dout, ir;
  logic [3:0] flags;
  logic       busy, sp_err;

  logic       resp_ack, late_ack;
  logic [7:0] rd_data;
  int         ack_delay;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;
  txn_t exp_q[$];

  logic [7:0] ma_m;

  param_data_path_if #(.DATA_W(8), .ADDR_W(8)) mem_if ();

  assign mem_if.mem_ack   = resp_ack | late_ack;
  assign mem_if.mem_rdata = rd_data;

  param_data_path dut (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .i_transfer_cmd  (cmd),
    .i_alu_calculate (calc),
    .i_alu_op        (op),
    .i_alu_res_to_ap (to_ap),
    .i_cond          (cond),
    .i_inc_pc        (inc_pc),
    .i_inc_dec_sp    (incdec),
    .i_reset_ir      (rst_ir),
    .i_in            (din),
    .o_out           (dout),
    .o_ir            (ir),
    .o_flags         (flags),
    .o_busy          (busy),
    .o_sp_err        (sp_err),
    .o_mem_req       (mem_if.mem_req),
    .o_mem_we        (mem_if.mem_we),
    .o_mem_addr      (mem_if.mem_addr),
    .o_mem_wdata     (mem_if.mem_wdata),
    .i_mem_ack       (mem_if.mem_ack),
    .i_mem_rdata     (mem_if.mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] c, input logic cl = 0, input logic [3:0] o = 0,
                      input logic ap = 0, input logic [1:0] cd = 0, input logic ip = 0,
                      input logic [1:0] sd = 0, input logic ri = 0);
    cmd = c; calc = cl; op = o; to_ap = ap; cond = cd; inc_pc = ip; incdec = sd; rst_ir = ri;
    tick();
    cmd = 0; calc = 0; op = 0; to_ap = 0; cond = 0; inc_pc = 0; incdec = 0; rst_ir = 0;
  endtask

  task automatic load_a(input logic [7:0] v);
    din = v;
    tick();
    step(4'hC);
  endtask

  task automatic load_md(input logic [7:0] v);
    load_a(v);
    step(4'h8);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200 && busy; k++) tick();
    if (busy) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  // Issue a write of MD at the modelled MA and queue what the bus must show.
  task automatic obs_md(input logic [7:0] exp_md);
    exp_q.push_back('{we: 1'b1, addr: ma_m, wdata: exp_md});
    ack_delay = 1;
    step(4'h9);
    wait_idle();
  endtask

  // Read cycle with cmd 1 presented on the first busy cycle; returns busy length.
  task automatic mem_read(input int dly, input logic [7:0] data, output int busy_n);
    exp_q.push_back('{we: 1'b0, addr: ma_m, wdata: 8'h00});
    ack_delay = dly;
    rd_data = data;
    busy_n = 0;
    cmd = 4'h2;
    tick();
    cmd = 4'h1;
    for (int k = 0; k < 50 && busy; k++) begin
      busy_n++;
      tick();
      cmd = 4'h0;
    end
    cmd = 4'h0;
  endtask

  initial begin : responder
    int cnt;
    resp_ack = 0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (resp_ack) begin
        resp_ack = 0;
        cnt = 0;
      end else if (mem_if.mem_req) begin
        if (cnt == ack_delay) resp_ack = 1;
        else cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    logic       prev_req;
    logic [7:0] held_addr;
    txn_t       t;
    prev_req = 0;
    held_addr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_if.mem_req && !prev_req) begin
        held_addr = mem_if.mem_addr;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_req actual=%0h required=none", mem_if.mem_addr);
        end else begin
          t = exp_q.pop_front();
          check("req_we", mem_if.mem_we, t.we);
          check("req_addr", mem_if.mem_addr, t.addr);
          if (t.we) check("req_wdata", mem_if.mem_wdata, t.wdata);
        end
      end else if (mem_if.mem_req) begin
        check("req_addr_hold", mem_if.mem_addr, held_addr);
      end
      prev_req = mem_if.mem_req;
    end
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] md;
    logic [7:0] r;
    logic [3:0] f;
  } alu_vec_t;

  alu_vec_t vecs[8] = '{
    '{4'h5, 8'hAA, 8'hFF, 8'h55, 4'h0},
    '{4'h4, 8'hF0, 8'h0F, 8'h00, 4'h1},
    '{4'h6, 8'h81, 8'h00, 8'h40, 4'h2},
    '{4'h7, 8'h81, 8'h00, 8'h02, 4'h2},
    '{4'h2, 8'h0F, 8'h00, 8'hF0, 4'h4},
    '{4'h0, 8'hFF, 8'h01, 8'h00, 4'h3},
    '{4'hF, 8'h12, 8'h34, 8'hFF, 4'h4},
    '{4'h1, 8'h80, 8'h01, 8'h7F, 4'h8}
  };

  initial begin : stim
    int bn;
    rstn = 0; cmd = 0; calc = 0; op = 0; to_ap = 0; cond = 0;
    inc_pc = 0; incdec = 0; rst_ir = 0; din = 0;
    late_ack = 0; rd_data = 0; ack_delay = 1; ma_m = 0;
    repeat (3) tick();
    check("rst_flags", flags, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_sp_err", sp_err, 1'b0);
    check("rst_mem_req", mem_if.mem_req, 1'b0);
    check("rst_mem_addr", mem_if.mem_addr, 8'h00);
    check("rst_out", dout, 8'h00);
    check("rst_ir", ir, 8'h00);
    rstn = 1;
    tick();

    // SP reset value through MA, PC reset value through MD.
    step(4'h7); ma_m = 8'h7F;
    step(4'hF);
    obs_md(8'h00);

    // Signed overflow on ADD.
    load_md(8'h01);
    load_a(8'h7F);
    step(4'h0, 1, 4'h0);
    check("add_ovf_flags", flags, 4'hC);
    step(4'hA);
    step(4'hD);
    check("add_ovf_out", dout, 8'h80);

    // Borrow on SUB.
    load_a(8'h00);
    step(4'h0, 1, 4'h1);
    check("sub_borrow_flags", flags, 4'h6);
    step(4'hA);
    step(4'h8);
    obs_md(8'hFF);

    foreach (vecs[i]) begin
      load_md(vecs[i].md);
      load_a(vecs[i].a);
      step(4'h0, 1, vecs[i].op);
      check($sformatf("alu_op%0h_flags", vecs[i].op), flags, vecs[i].f);
      step(4'hA);
      step(4'hD);
      check($sformatf("alu_op%0h_res", vecs[i].op), dout, vecs[i].r);
    end

    // AP path: MD -> AP -> MA.
    load_md(8'h33);
    step(4'h5, 0, 0, 1);
    step(4'h6); ma_m = 8'h33;
    obs_md(8'h33);

    // Read with a 3-cycle ack delay; MA must survive a cmd 1 while busy.
    load_md(8'h10);
    step(4'h4); ma_m = 8'h10;
    mem_read(3, 8'hA5, bn);
    check("read_busy_cycles", bn, 4);
    step(4'h3);
    check("read_ir", ir, 8'hA5);
    mem_read(0, 8'h5A, bn);
    check("read_min_latency", bn, 1);
    step(4'h3, 0, 0, 0, 0, 0, 0, 1);
    check("reset_ir_wins", ir, 8'h00);
    step(4'h3);
    check("read2_ir", ir, 8'h5A);

    // Conditional branch on Z, taken and not taken.
    load_md(8'h42);
    load_a(8'h00);
    step(4'h0, 1, 4'h4);
    check("z_set_flags", flags, 4'h1);
    step(4'hB, 0, 0, 0, 2'b01, 1);
    step(4'hF);
    obs_md(8'h42);
    load_a(8'h01);
    step(4'h0, 1, 4'h3);
    check("z_clr_flags", flags, 4'h0);
    step(4'hB, 0, 0, 0, 2'b01, 1);
    step(4'hF);
    obs_md(8'h43);

    // SP underflow wrap and sticky error.
    repeat (127) step(4'h0, 0, 0, 0, 0, 0, 2'b10);
    check("sp_err_before_wrap", sp_err, 1'b0);
    step(4'h0, 0, 0, 0, 0, 0, 2'b10);
    check("sp_err_at_wrap", sp_err, 1'b1);
    step(4'h7); ma_m = 8'hFF;
    obs_md(8'h43);
    step(4'h0, 0, 0, 0, 0, 0, 2'b01);
    repeat (3) tick();
    check("sp_err_sticky", sp_err, 1'b1);

    // Reset in the middle of a read, then a late ack.
    exp_q.push_back('{we: 1'b0, addr: ma_m, wdata: 8'h00});
    ack_delay = 1000;
    rd_data = 8'hEE;
    step(4'h2);
    tick();
    check("midreq_busy", busy, 1'b1);
    rstn = 0;
    tick();
    check("midreq_rst_req", mem_if.mem_req, 1'b0);
    check("midreq_rst_addr", mem_if.mem_addr, 8'h00);
    check("midreq_rst_sp_err", sp_err, 1'b0);
    rstn = 1;
    late_ack = 1;
    tick();
    late_ack = 0;
    check("late_ack_busy", busy, 1'b0);
    check("late_ack_req", mem_if.mem_req, 1'b0);
    step(4'h7); ma_m = 8'h7F;
    obs_md(8'h00);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/param_data_path.md
PARAM_DATA_PATH -- requirements
Module: param_data_path

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath/register width (>=8).
REQ-002 SHALL have parameter ADDR_W, default 8, memory address and SP width (<=DATA_W).
REQ-003 SHALL have parameter SP_INIT, default 2**(ADDR_W-1)-1, stack pointer reset value.
REQ-004 SHALL have ports: i_clk in 1 clock; i_rstn in 1 synchronous active-low reset; one clock, no other reset.
REQ-005 SHALL have ports: i_transfer_cmd in 4 transfer code (0 = none); i_alu_calculate in 1; i_alu_op in 4; i_alu_res_to_ap in 1 (operand/destination AP instead of A); i_cond in 2 branch condition.
REQ-006 SHALL have ports: i_inc_pc in 1; i_inc_dec_sp in 2 (01 inc, 10 dec); i_reset_ir in 1; i_in in DATA_W; o_out out DATA_W; o_ir out DATA_W.
REQ-007 SHALL have ports: o_flags out 4 {V,N,C,Z}; o_busy out 1; o_sp_err out 1 sticky stack fault.
REQ-008 SHALL have ports: o_mem_req out 1; o_mem_we out 1; o_mem_addr out ADDR_W; o_mem_wdata out DATA_W; i_mem_ack in 1; i_mem_rdata in DATA_W.

Function
REQ-009 Transfers SHALL be: 1 MA<=PC; 2 memory read into MD; 3 IR<=MD; 4 MA<=MD; 5 A/AP<=MD; 6 MA<=AP; 7 MA<=SP; 8 MD<=A/AP; 9 memory write of MD; A A/AP<=R; B PC<=MD if condition; C A<=IN; D OUT<=A; E PC<=AP; F MD<=PC.
REQ-010 A/AP selection SHALL follow i_alu_res_to_ap; MA loads SHALL take low ADDR_W bits; MD<=PC/SP SHALL zero-extend.
REQ-011 Condition (cmd B) SHALL be: 00 always, 01 Z, 10 C, 11 N, sampled from o_flags at the command edge.
REQ-012 Memory FSM SHALL have states IDLE, REQ; cmd 2/9 in IDLE SHALL enter REQ next edge with o_mem_req=1, o_mem_addr=MA, o_mem_we=1 (write) and o_mem_wdata=MD.
REQ-013 In REQ, o_mem_req/we/addr/wdata SHALL hold stable until the cycle i_mem_ack=1; on that edge FSM SHALL return to IDLE and, for reads, MD<=i_mem_rdata.
REQ-014 o_busy SHALL equal (state==REQ); all transfer commands while busy SHALL be ignored; minimum read latency 2 edges.
REQ-015 IN SHALL register i_in every cycle; o_out SHALL be OUT; o_ir SHALL be IR.
REQ-016 ALU ops SHALL be: 0 ADD, 1 SUB, 2 NOT, 3 OR, 4 AND, 5 XOR, 6 SHR logical, 7 SHL; first operand A or AP, second MD; R<=result when i_alu_calculate.
REQ-017 Flags SHALL update with R: Z=result zero; N=result MSB; C=carry-out of DATA_W+1-bit add, borrow for SUB, shifted-out bit for shifts, 0 for logic ops; V=signed overflow for ADD/SUB, else 0.
REQ-018 Undefined ops SHALL give R all ones, C=0, V=0, Z/N from result.
REQ-019 PC/SP SHALL wrap modulo 2**width; SP inc at all-ones or dec at zero SHALL set o_sp_err (sticky) and still wrap.
REQ-020 Simultaneous: PC load (cmd B taken/E) SHALL win over i_inc_pc; i_reset_ir SHALL win over cmd 3; cmd A SHALL write old R when i_alu_calculate also set.

Reset
REQ-021 On i_clk edge with i_rstn=0: all registers, flags, o_sp_err, memory outputs = 0, SP=SP_INIT, FSM=IDLE.
REQ-022 Reset during REQ SHALL drop o_mem_req at that edge; a late i_mem_ack SHALL be ignored.

Configuration
REQ-023 With EDU_DP_ROTATE_EN defined, ops 8 ROR-through-C and 9 ROL-through-C SHALL exist (C=bit rotated out, V=0); without it they SHALL behave per REQ-018.

Structure
REQ-024 Package edu_dp_pkg SHALL hold transfer-code, ALU-op, condition and FSM-state enums plus flag index constants.
REQ-025 Combinational ALU SHALL be sub-module edu_dp_alu (DATA_W parameter, result plus four flags).

Verification
REQ-026 DATA_W=8: A=0x7F, MD=0x01, ADD, cmd A -> A=0x80, N=1, V=1, C=0, Z=0.
REQ-027 A=0x00, MD=0x01, SUB -> R=0xFF, C=1 (borrow), N=1.
REQ-028 MA=0x10, cmd 2, ack after 3 cycles with rdata 0xA5 -> o_busy 4 cycles, MD=0xA5, cmd 1 during busy leaves MA=0x10.
REQ-029 SP reset 0x7F; 128 decrements -> SP=0x7F wraps from 0x00 to 0xFF, o_sp_err=1 and held.
REQ-030 Z=1, i_cond=01, cmd B with i_inc_pc -> PC=MD; Z=0 -> PC=PC+1.
REQ-031 i_rstn low mid-REQ then ack -> o_mem_req=0, MD unchanged, SP=SP_INIT.
